// File: rtl/cp0_irq_timer_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR layout.
package cp0_irq_timer_pkg;

   typedef enum logic [4:0] {
      REG_BADVADDR = 5'd8,
      REG_COUNT    = 5'd9,
      REG_COMPARE  = 5'd11,
      REG_SR       = 5'd12,
      REG_CAUSE    = 5'd13,
      REG_EPC      = 5'd14,
      REG_PRID     = 5'd15
   } cp0_reg_e;

   localparam logic [4:0] CAUSE_INT  = 5'd0;
   localparam logic [4:0] CAUSE_ADEL = 5'd4;
   localparam logic [4:0] CAUSE_ADES = 5'd5;
   // ERET is reported through the exception path with a code no real exception uses
   localparam logic [4:0] CAUSE_ERET = 5'd31;

   typedef struct packed {
      logic [7:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

   function automatic logic is_addr_err(input logic [4:0] code);
      return (code == CAUSE_ADEL) || (code == CAUSE_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count with a sticky match flag.
import cp0_irq_timer_pkg::*;

module cp0_timer #(
   parameter int COUNT_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_write,
   input  logic        compare_write,
   input  logic [31:0] write_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pending
);

   logic        tick;
   logic [31:0] count_next;

   generate
      if (COUNT_DIV == 0) begin : g_nodiv
         assign tick = 1'b1;
      end else begin : g_div
         logic [COUNT_DIV-1:0] presc;
         always_ff @(posedge clk) begin
            if (reset) presc <= '0;
            else       presc <= presc + 1'b1;
         end
         assign tick = &presc;
      end
   endgenerate

   assign count_next = count + 32'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         pending <= 1'b0;
      end else begin
         if (count_write)  count <= write_data;
         else if (tick)    count <= count_next;
         if (compare_write) compare <= write_data;
         // only a real increment can match, so the reset state 0 == 0 never fires
         if (compare_write)
            pending <= 1'b0;
         else if (tick && !count_write && (count_next == compare))
            pending <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_irq_timer.sv
// Coprocessor 0 with synchronised external IRQs, software IRQs, timer and BadVAddr.
import cp0_irq_timer_pkg::*;

module cp0_irq_timer #(
   parameter int          NUM_IRQ    = 6,
   parameter logic [31:0] EXC_VECTOR = 32'h00004180,
   parameter logic [31:0] PRID_VALUE = 32'hDEADBEEF,
   parameter int          COUNT_DIV  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               writeEnable,
   input  logic [4:0]         number,
   input  logic [31:0]        writeData,
   output logic [31:0]        readData,
   input  logic               hasExceptionInPipeline,
   input  logic               isException,
   input  logic               isBD,
   input  logic [4:0]         exceptionCause,
   input  logic [31:0]        exceptionPC,
   input  logic [31:0]        badVAddr,
   input  logic [NUM_IRQ-1:0] externalInterrupt,
   output logic               jump,
   output logic [31:0]        jumpAddress,
   output logic               interruptNow,
   output logic               timerPending
);

   logic [NUM_IRQ-1:0] sync1, sync2;
   logic [5:0]         ext_wide, ip_ext;
   sr_t                sr;
   logic               bd;
   logic [1:0]         ip_sw;
   logic [4:0]         exc_code;
   logic [31:0]        epc, bad_vaddr, count, compare;
   logic [7:0]         ip;
   logic [31:0]        sr_val, cause_val;
   logic               exc_take, eret_take;
   logic               wr_sr, wr_cause, wr_epc, wr_count, wr_compare;

   assign wr_sr      = writeEnable && (number == REG_SR);
   assign wr_cause   = writeEnable && (number == REG_CAUSE);
   assign wr_epc     = writeEnable && (number == REG_EPC);
   assign wr_count   = writeEnable && (number == REG_COUNT);
   assign wr_compare = writeEnable && (number == REG_COMPARE);

   assign exc_take  = isException && !sr.exl && (exceptionCause != CAUSE_ERET);
   assign eret_take = isException &&  sr.exl && (exceptionCause == CAUSE_ERET);

   always_comb begin
      ext_wide = '0;
      ext_wide[NUM_IRQ-1:0] = sync2;
   end

   // ip_ext is a third stage so a line shows in Cause two edges after it is first sampled
   assign ip        = {ip_ext[5] | timerPending, ip_ext[4:0], ip_sw};
   assign sr_val    = {16'h0, sr.im, 6'h0, sr.exl, sr.ie};
   assign cause_val = {bd, 15'h0, ip, 1'b0, exc_code, 2'b00};

   assign interruptNow = sr.ie && !sr.exl && !hasExceptionInPipeline && |(ip & sr.im);
   assign jump         = exc_take || eret_take;
   assign jumpAddress  = eret_take ? epc : EXC_VECTOR;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk           (clk),
      .reset         (reset),
      .count_write   (wr_count),
      .compare_write (wr_compare),
      .write_data    (writeData),
      .count         (count),
      .compare       (compare),
      .pending       (timerPending)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         ip_ext    <= '0;
         sr        <= '{im: 8'hFF, exl: 1'b1, ie: 1'b0};
         bd        <= 1'b0;
         ip_sw     <= '0;
         exc_code  <= CAUSE_INT;
         epc       <= '0;
         bad_vaddr <= '0;
      end else begin
         sync1  <= externalInterrupt;
         sync2  <= sync1;
         ip_ext <= ext_wide;
         if (wr_sr) begin
            sr.im  <= writeData[15:8];
            sr.exl <= writeData[1];
            sr.ie  <= writeData[0];
         end
         if (wr_cause) ip_sw <= writeData[9:8];
         if (wr_epc)   epc   <= writeData;
         // later assignments win: exception/ERET override the mtc0 on EPC and EXL
         if (exc_take) begin
            sr.exl   <= 1'b1;
            bd       <= isBD;
            exc_code <= exceptionCause;
            epc      <= isBD ? exceptionPC - 32'd4 : exceptionPC;
            if (is_addr_err(exceptionCause)) bad_vaddr <= badVAddr;
         end else if (eret_take) begin
            sr.exl <= 1'b0;
         end
      end
   end

   always_comb begin
      readData = '0;
      case (number)
         REG_BADVADDR: readData = bad_vaddr;
         REG_COUNT:    readData = count;
         REG_COMPARE:  readData = compare;
         REG_SR:       readData = sr_val;
         REG_CAUSE:    readData = cause_val;
         REG_EPC:      readData = epc;
         REG_PRID:     readData = PRID_VALUE;
         default:      readData = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Scoreboard bench for cp0_irq_timer: directed plan plus random traffic against a register-level model.
module tb_cp0_irq_timer;

   localparam int          NIRQ = 6;
   localparam int          CDIV = 0;
   localparam logic [31:0] VEC  = 32'h00004180;
   localparam logic [31:0] PRID = 32'hDEADBEEF;
   localparam logic [4:0]  ERET = 5'd31;

   logic            clk = 1'b0;
   logic            reset, writeEnable, hasExceptionInPipeline, isException, isBD;
   logic [4:0]      number, exceptionCause;
   logic [31:0]     writeData, readData, exceptionPC, badVAddr, jumpAddress;
   logic [NIRQ-1:0] externalInterrupt;
   logic            jump, interruptNow, timerPending;

   cp0_irq_timer #(.NUM_IRQ(NIRQ), .EXC_VECTOR(VEC), .PRID_VALUE(PRID), .COUNT_DIV(CDIV)) dut (
      .clk(clk), .reset(reset), .writeEnable(writeEnable), .number(number),
      .writeData(writeData), .readData(readData),
      .hasExceptionInPipeline(hasExceptionInPipeline), .isException(isException),
      .isBD(isBD), .exceptionCause(exceptionCause), .exceptionPC(exceptionPC),
      .badVAddr(badVAddr), .externalInterrupt(externalInterrupt), .jump(jump),
      .jumpAddress(jumpAddress), .interruptNow(interruptNow), .timerPending(timerPending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, we, hex, exc, bd;
      logic [4:0] num, cause;
      logic [31:0] wd, pc, bva;
      logic [NIRQ-1:0] ext;
   } in_t;

   typedef struct {
      logic [4:0] num;
      logic [31:0] rd, ja;
      logic jump, irq, tp;
   } exp_t;

   exp_t sbq[$];
   int tests = 0, fails = 0;
   logic [NIRQ-1:0] ext_lvl = '0;

   // architectural model state
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_tp;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_exc;
   logic [31:0] m_epc, m_bva, m_cnt, m_cmp;
   int          m_presc;
   logic [NIRQ-1:0] h1, h2, h3;

   function automatic logic [7:0] m_ip();
      logic [7:0] ip = '0;
      for (int i = 0; i < NIRQ; i++) ip[2+i] = h3[i];
      ip[7] = ip[7] | m_tp;
      ip[1:0] = m_ipsw;
      return ip;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] n);
      case (n)
         5'd8:  return m_bva;
         5'd9:  return m_cnt;
         5'd11: return m_cmp;
         5'd12: return {16'h0, m_im, 6'h0, m_exl, m_ie};
         5'd13: return {m_bd, 15'h0, m_ip(), 1'b0, m_exc, 2'b00};
         5'd14: return m_epc;
         5'd15: return PRID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic exp_t m_out(input in_t x);
      exp_t e;
      logic exc_ok  = x.exc && !m_exl && (x.cause != ERET);
      logic eret_ok = x.exc && m_exl && (x.cause == ERET);
      e.num  = x.num;
      e.rd   = m_read(x.num);
      e.jump = exc_ok || eret_ok;
      e.ja   = eret_ok ? m_epc : VEC;
      e.irq  = m_ie && !m_exl && !x.hex && ((m_ip() & m_im) != 8'h0);
      e.tp   = m_tp;
      return e;
   endfunction

   task automatic model_edge(input in_t x);
      logic tick, exc_ok, eret_ok;
      logic [31:0] inc;
      if (x.rst) begin
         m_im = 8'hFF; m_exl = 1'b1; m_ie = 1'b0; m_bd = 1'b0; m_tp = 1'b0;
         m_ipsw = '0; m_exc = '0; m_epc = '0; m_bva = '0; m_cnt = '0; m_cmp = '0;
         m_presc = 0; h1 = '0; h2 = '0; h3 = '0;
         return;
      end
      tick    = (m_presc == (1 << CDIV) - 1);
      m_presc = (m_presc + 1) % (1 << CDIV);
      exc_ok  = x.exc && !m_exl && (x.cause != ERET);
      eret_ok = x.exc && m_exl && (x.cause == ERET);
      inc     = m_cnt + 32'd1;
      if (x.we && x.num == 5'd11) m_tp = 1'b0;
      else if (tick && !(x.we && x.num == 5'd9) && inc == m_cmp) m_tp = 1'b1;
      if (x.we && x.num == 5'd9) m_cnt = x.wd;
      else if (tick) m_cnt = inc;
      if (x.we && x.num == 5'd11) m_cmp = x.wd;
      if (x.we && x.num == 5'd12) begin
         m_im = x.wd[15:8]; m_exl = x.wd[1]; m_ie = x.wd[0];
      end
      if (x.we && x.num == 5'd13) m_ipsw = x.wd[9:8];
      if (x.we && x.num == 5'd14) m_epc = x.wd;
      if (exc_ok) begin
         m_exl = 1'b1; m_bd = x.bd; m_exc = x.cause;
         m_epc = x.bd ? x.pc - 32'd4 : x.pc;
         if (x.cause == 5'd4 || x.cause == 5'd5) m_bva = x.bva;
      end else if (eret_ok) begin
         m_exl = 1'b0;
      end
      h3 = h2; h2 = h1; h1 = x.ext;
   endtask

   task automatic apply(input in_t x);
      reset = x.rst; writeEnable = x.we; number = x.num; writeData = x.wd;
      hasExceptionInPipeline = x.hex; isException = x.exc; isBD = x.bd;
      exceptionCause = x.cause; exceptionPC = x.pc; badVAddr = x.bva;
      externalInterrupt = x.ext;
   endtask

   // apply for one cycle, queue the expected outputs, then advance the model at the edge
   task automatic drive(input in_t x);
      apply(x);
      sbq.push_back(m_out(x));
      @(posedge clk);
      model_edge(x);
      #1;
   endtask

   function automatic in_t base();
      in_t x;
      x.rst = 0; x.we = 0; x.hex = 0; x.exc = 0; x.bd = 0;
      x.num = 5'd0; x.cause = 5'd0; x.wd = '0; x.pc = '0; x.bva = '0;
      x.ext = ext_lvl;
      return x;
   endfunction

   task automatic rd(input logic [4:0] n);
      in_t x = base();
      x.num = n;
      drive(x);
   endtask

   task automatic wr(input logic [4:0] n, input logic [31:0] d);
      in_t x = base();
      x.we = 1'b1; x.num = n; x.wd = d;
      drive(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("readData[%0d]", e.num), readData, e.rd);
         chk("jump", {31'h0, jump}, {31'h0, e.jump});
         if (e.jump) chk("jumpAddress", jumpAddress, e.ja);
         chk("interruptNow", {31'h0, interruptNow}, {31'h0, e.irq});
         chk("timerPending", {31'h0, timerPending}, {31'h0, e.tp});
      end
   end

   initial begin
      in_t x;
      x = base(); x.rst = 1'b1;
      apply(x);
      @(posedge clk); model_edge(x); #1;
      drive(x);

      // reset values
      rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15);

      // external line 0 through the synchroniser, then masked by a pipeline exception
      wr(5'd12, 32'h00000401);
      ext_lvl = 6'b000001;
      repeat (4) rd(5'd13);
      x = base(); x.hex = 1'b1; x.num = 5'd13;
      repeat (2) drive(x);
      ext_lvl = '0;
      repeat (4) rd(5'd13);

      // AdEL in a delay slot, then a second exception ignored while EXL=1
      x = base(); x.exc = 1'b1; x.cause = 5'd4; x.bd = 1'b1;
      x.pc = 32'h3008; x.bva = 32'h1235; x.num = 5'd14;
      drive(x);
      rd(5'd14); rd(5'd13); rd(5'd8); rd(5'd12);
      x.cause = 5'd0; x.pc = 32'h5000; x.bd = 1'b0;
      drive(x);
      rd(5'd14); rd(5'd13);

      // ERET honoured once, then ignored with EXL=0
      x = base(); x.exc = 1'b1; x.cause = ERET; x.num = 5'd12;
      drive(x);
      rd(5'd12);
      drive(x);

      // timer: match, run past, clear via Compare, wrap
      wr(5'd11, 32'd5); wr(5'd9, 32'd0); wr(5'd12, 32'h00008001);
      repeat (8) rd(5'd9);
      wr(5'd11, 32'd100); rd(5'd9);
      wr(5'd9, 32'hFFFFFFFF); rd(5'd9); rd(5'd9);

      // same-cycle mtc0 EPC and exception: exception wins
      wr(5'd12, 32'h00000001);
      x = base(); x.we = 1'b1; x.num = 5'd14; x.wd = 32'h1111;
      x.exc = 1'b1; x.cause = 5'd0; x.pc = 32'h2000;
      drive(x);
      rd(5'd14);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] regs [8];
         regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
         if ($urandom_range(0, 15) == 0) ext_lvl = NIRQ'($urandom);
         x = base();
         x.rst = ($urandom_range(0, 299) == 0);
         x.num = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : regs[$urandom_range(0, 7)];
         if ($urandom_range(0, 3) == 0) begin
            x.we = 1'b1;
            x.wd = $urandom;
            if (x.num == 5'd9 && $urandom_range(0, 1) == 1) x.wd = m_cmp - 32'($urandom_range(1, 8));
            if (x.num == 5'd12 && $urandom_range(0, 1) == 1) x.wd[1] = 1'b0;
         end
         x.hex = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) begin
            x.exc   = 1'b1;
            x.cause = ($urandom_range(0, 2) == 0) ? ERET : 5'($urandom_range(0, 31));
            x.bd    = 1'($urandom_range(0, 1));
            x.pc    = $urandom;
            x.bva   = $urandom;
         end
         drive(x);
      end

      repeat (2) @(posedge clk);
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cp0_irq_timer.md
Name: cp0_irq_timer

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core. It is the next generation of the single-file CP0 and adds the following:
- N synchronised external interrupt lines.
- Two software interrupt bits.
- A Count/Compare timer interrupt.
- A BadVAddr register.
- Field-level write masks on all architectural registers.

It sits beside the MEM/WB boundary. It takes exception and ERET reports from the pipeline and returns the redirect (jump/jumpAddress) plus the interruptNow request.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..6); line i maps to IP[10+i].
- EXC_VECTOR, 32'h00004180, exception handler address.
- PRID_VALUE, 32'hDEADBEEF, PrId read value.
- COUNT_DIV, 1, Count increments once every 2^COUNT_DIV cycles (0 = every cycle).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- writeEnable  in  1  mtc0 strobe
- number  in  5  CP0 register select (read and write)
- writeData  in  32  mtc0 data
- readData  out  32  mfc0 data, combinational from number
- hasExceptionInPipeline  in  1  blocks interrupt request while asserted
- isException  in  1  exception/ERET report valid this cycle
- isBD  in  1  faulting instruction is in a delay slot
- exceptionCause  in  5  ExcCode; causeERET from constants.v
- exceptionPC  in  32  PC of reporting instruction
- badVAddr  in  32  faulting address for AdEL/AdES
- externalInterrupt  in  NUM_IRQ  asynchronous level-sensitive lines
- jump  out  1  redirect fetch, combinational
- jumpAddress  out  32  redirect target; don't-care when jump=0
- interruptNow  out  1  take interrupt at current instruction, combinational
- timerPending  out  1  timer interrupt pending flag (debug/observation)

Behaviour:
- Registers and write masks:
  - BadVAddr(8): read-only.
  - Count(9): R/W, 32-bit.
  - Compare(11): R/W, 32-bit.
  - SR(12): writable bits IM[15:8], EXL[1], IE[0]; others read 0.
  - Cause(13): only IP[9:8] writable; BD[31], IP[15:10], ExcCode[6:2] are hardware-only.
  - EPC(14): R/W.
  - PrId(15): constant PRID_VALUE.
  - Other numbers: read 0, writes ignored.
- Reset values: SR = IM 8'hFF, EXL=1, IE=0. Cause=0, EPC=0, Count=0, Compare=0, BadVAddr=0, timerPending=0, synchronisers=0. Outputs jump=0, interruptNow=0.
- Register writes take effect at the clk edge; readData shows the new value the following cycle.
- External interrupts:
  - Two-flop synchroniser per line.
  - A line rising before edge N appears in IP[10+i] after edge N+2.
  - IP[15:10] tracks the synchronised level every cycle, not only on interrupt.
  - Bits at or above 10+NUM_IRQ read 0.
- Timer:
  - Prescaler counts 0..2^COUNT_DIV-1; Count increments (wrapping) when the prescaler wraps.
  - timerPending sets on the edge where the incremented Count equals Compare.
  - Reset-time equality (Count = Compare = 0) does not fire; only an increment sets pending.
  - Clears only on an mtc0 write to Compare.
  - Cause.IP[15] = synchronised line 5 (if present) OR timerPending.
- Interrupt request:
  - pendingVec = Cause.IP[15:8] & SR.IM.
  - interruptNow = IE & !EXL & !hasExceptionInPipeline & |pendingVec.
  - Purely combinational, no latency beyond the register state.
- Exception (isException, EXL=0, cause≠ERET):
  - jump=1, jumpAddress=EXC_VECTOR in the same cycle.
  - Next edge: BD=isBD; ExcCode=cause; EPC = isBD ? exceptionPC-4 : exceptionPC; EXL=1.
  - BadVAddr=badVAddr if cause is AdEL(4) or AdES(5), otherwise unchanged.
- ERET (isException, cause=ERET, EXL=1): jump=1, jumpAddress=EPC; next edge EXL=0.
- Ignored cases (jump=0, no state change):
  - ERET with EXL=0.
  - Non-ERET exception with EXL=1.
- Simultaneous events:
  - Exception/ERET update and mtc0 in the same cycle: hardware update wins for EPC, Cause, and SR.EXL; the write still applies to the remaining writable fields.
  - mtc0 Count on an increment edge: the write wins.
  - mtc0 Compare on a match edge: the write wins and pending is cleared.
  - Software IP writes coexist with hardware IP updates (disjoint bits).
- Reset mid-operation: all state returns to reset values at the edge regardless of other inputs.

Decomposition:
- constants.v (shared):
  - CP0 register numbers.
  - Cause codes: causeInt=0, AdEL=4, AdES=5, causeERET.
  - SR/Cause bit positions.
- Sub-module cp0_timer: prescaler, Count, Compare, and pending flag. Ports: clk, reset, Count/Compare write strobes and data, count, compare, pending.
- Everything else stays in cp0_irq_timer.

Test Plan:
- Reset; read 12,13,14,15 → SR=0x0000FF02, Cause=0, EPC=0, PrId=0xDEADBEEF; jump=0, interruptNow=0.
- SR=0x00000401; raise externalInterrupt[0] before edge N → Cause=0x00000400 after edge N+2, interruptNow=1. Repeat with hasExceptionInPipeline=1 → interruptNow stays 0.
- Exception cause 4, isBD=1, PC=0x3008, badVAddr=0x1235 → jump=1, target 0x4180. Next cycle: EPC=0x3004, Cause=0x80000010, BadVAddr=0x1235, EXL=1. A second exception while EXL=1 → jump=0, no change.
- ERET with EXL=1, EPC=0x3004 → jump=1, target 0x3004, EXL=0 next cycle. ERET again with EXL=0 → jump=0.
- COUNT_DIV=0, Compare=5, Count=0, SR=0x00008001 → timerPending and interruptNow rise on the 5th increment. Count keeps running past 5. Writing Compare clears pending. Count=0xFFFFFFFF wraps to 0.
- Same-cycle mtc0 EPC=0x1111 and exception at PC=0x2000 → EPC=0x2000.
